// File: rtl/hqm_system_mem_pg_2048x16_ctl.sv
// rtl/hqm_system_mem_pg_2048x16_ctl.sv - power-gated 2048x16 SRAM controller
// Round-robin A/B arbitration, tagged read return and power-gate sequencing.
module hqm_system_mem_pg_2048x16_ctl #(
  parameter int IDLE_LIMIT = 256,
  parameter int ISO_SETTLE = 4,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        clk_rst,
  input  logic        a_req_v,
  input  logic        a_req_we,
  input  logic [10:0] a_req_addr,
  input  logic [15:0] a_req_wdata,
  output logic        a_req_rdy,
  input  logic        b_req_v,
  input  logic        b_req_we,
  input  logic [10:0] b_req_addr,
  input  logic [15:0] b_req_wdata,
  output logic        b_req_rdy,
  output logic        rsp_v,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        force_on,
  output logic [2:0]  pwr_state,
  output logic        mem_re,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        pgcb_isol_en,
  output logic        pwr_enable_b_in,
  input  logic        pwr_enable_b_out
);

  localparam logic [2:0] OFF     = 3'd0;
  localparam logic [2:0] PWR_UP  = 3'd1;
  localparam logic [2:0] ISO_REL = 3'd2;
  localparam logic [2:0] ON      = 3'd3;
  localparam logic [2:0] ISO_ON  = 3'd4;
  localparam logic [2:0] PWR_DN  = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [3:0]        iso_cnt;
  logic [15:0]       idle_cnt;
  logic              rr_b;
  logic [RD_LAT-1:0] pipe_v, pipe_id;
  logic              on, grant_a, grant_b, grant;

  // rr_b set means B is favoured when both requesters are valid
  assign on      = (state == ON);
  assign grant_a = on && a_req_v && (!b_req_v || !rr_b);
  assign grant_b = on && b_req_v && !grant_a;
  assign grant   = grant_a || grant_b;

  assign a_req_rdy = grant_a;
  assign b_req_rdy = grant_b;
  assign mem_re    = (grant_a && !a_req_we) || (grant_b && !b_req_we);
  assign mem_we    = (grant_a && a_req_we) || (grant_b && b_req_we);
  assign mem_addr  = grant_a ? a_req_addr : (grant_b ? b_req_addr : 11'd0);
  assign mem_wdata = grant_a ? a_req_wdata : (grant_b ? b_req_wdata : 16'd0);

  // Power stays applied through ISO_ON; isolation is released only in ON
  assign pwr_state       = state;
  assign pgcb_isol_en    = !on;
  assign pwr_enable_b_in = !(state == PWR_UP || state == ISO_REL || on || state == ISO_ON);

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (a_req_v || b_req_v || force_on) state_nxt = PWR_UP;
      PWR_UP:  if (!pwr_enable_b_out) state_nxt = ISO_REL;
      ISO_REL: if (iso_cnt == 4'(ISO_SETTLE - 1)) state_nxt = ON;
      ON:      if (!force_on && !grant && (idle_cnt >= 16'(IDLE_LIMIT)) && !(|pipe_v))
                 state_nxt = ISO_ON;
      ISO_ON:  state_nxt = PWR_DN;
      PWR_DN:  if (pwr_enable_b_out) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      state    <= OFF;
      iso_cnt  <= 4'd0;
      idle_cnt <= 16'd0;
      rr_b     <= 1'b0;
      pipe_v   <= '0;
      pipe_id  <= '0;
      rsp_v    <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= 16'd0;
    end else begin
      state   <= state_nxt;
      iso_cnt <= (state == ISO_REL) ? iso_cnt + 4'd1 : 4'd0;
      if (!on || grant || force_on)
        idle_cnt <= 16'd0;
      else if (idle_cnt != 16'hffff)
        idle_cnt <= idle_cnt + 16'd1;
      if (grant)
        rr_b <= grant_a;
      // Read tags travel alongside the SRAM latency; data is captured at the tail
      pipe_v[0]  <= mem_re;
      pipe_id[0] <= grant_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      rsp_v <= pipe_v[RD_LAT-1];
      if (pipe_v[RD_LAT-1]) begin
        rsp_id   <= pipe_id[RD_LAT-1];
        rsp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hqm_system_mem_pg_2048x16_ctl.sv
// tb/tb_hqm_system_mem_pg_2048x16_ctl.sv - directed bench with response scoreboard
module tb_hqm_system_mem_pg_2048x16_ctl;

  localparam int IDLE_LIMIT = 8;
  localparam int ISO_SETTLE = 4;
  localparam int RD_LAT     = 1;

  logic        clk = 1'b0;
  logic        clk_rst = 1'b1;
  logic        a_req_v = 1'b0, a_req_we = 1'b0;
  logic [10:0] a_req_addr = 11'd0;
  logic [15:0] a_req_wdata = 16'd0;
  logic        a_req_rdy;
  logic        b_req_v = 1'b0, b_req_we = 1'b0;
  logic [10:0] b_req_addr = 11'd0;
  logic [15:0] b_req_wdata = 16'd0;
  logic        b_req_rdy;
  logic        rsp_v, rsp_id;
  logic [15:0] rsp_data;
  logic        force_on = 1'b0;
  logic [2:0]  pwr_state;
  logic        mem_re, mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'd0;
  logic        pgcb_isol_en, pwr_enable_b_in;
  logic        pwr_enable_b_out = 1'b1;
  logic        ack_d1 = 1'b1;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sram    [2048];
  logic [15:0] ref_mem [2048];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  hqm_system_mem_pg_2048x16_ctl #(
    .IDLE_LIMIT(IDLE_LIMIT), .ISO_SETTLE(ISO_SETTLE), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .clk_rst(clk_rst),
    .a_req_v(a_req_v), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_req_rdy(a_req_rdy),
    .b_req_v(b_req_v), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_req_rdy(b_req_rdy),
    .rsp_v(rsp_v), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .force_on(force_on), .pwr_state(pwr_state),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pgcb_isol_en(pgcb_isol_en), .pwr_enable_b_in(pwr_enable_b_in),
    .pwr_enable_b_out(pwr_enable_b_out)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency and a power ack lagging enable by two cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
    ack_d1 <= pwr_enable_b_in;
    pwr_enable_b_out <= ack_d1;
  end

  always @(negedge clk) begin
    if (!clk_rst && rsp_v) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL rsp_unexpected id=%0d data=%h cyc=%0d required none", rsp_id, rsp_data, cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert ({rsp_id, rsp_data, cyc} === {e.id, e.data, e.due}) else begin
          miscompares++;
          $error("FAIL rsp id/data/cyc=%0d/%h/%0d required %0d/%h/%0d",
                 rsp_id, rsp_data, cyc, e.id, e.data, e.due);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of a grant cycle: checks the SRAM drive and books the reply
  task automatic note_grant(input logic id, input logic we, input logic [10:0] addr,
                            input logic [15:0] wdata, input bit push);
    exp_t e;
    check("grant_mem", {mem_re, mem_we, mem_addr, we ? mem_wdata : 16'd0},
          {!we, we, addr, we ? wdata : 16'd0});
    if (we) ref_mem[addr] = wdata;
    else if (push) begin
      e.id = id; e.data = ref_mem[addr]; e.due = cyc + RD_LAT + 1;
      sb.push_back(e);
    end
  endtask

  task automatic do_req(input logic id, input logic we, input logic [10:0] addr,
                        input logic [15:0] wdata, input bit push);
    bit got = 0;
    if (id) begin b_req_v = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; end
    else begin a_req_v = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (id ? b_req_rdy : a_req_rdy) begin
        got = 1;
        note_grant(id, we, addr, wdata, push);
      end
    end
    check("req_granted", 32'(got), 32'd1);
    @(posedge clk); #1;
    a_req_v = 0; b_req_v = 0;
  endtask

  initial begin
    int n;
    bit reached, left, got;
    logic [14:0] trace;
    for (int i = 0; i < 2048; i++) begin
      sram[i] = 16'(i * 3 + 16'h0101);
      ref_mem[i] = 16'(i * 3 + 16'h0101);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {29'd0, pwr_state}, 32'd0);
    check("reset_pwr", {pwr_enable_b_in, pgcb_isol_en}, 32'h3);
    check("reset_mem", {mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);
    check("reset_rsp", {a_req_rdy, b_req_rdy, rsp_v, rsp_id, rsp_data}, 32'd0);
    @(posedge clk); #1;
    clk_rst = 0;

    // Power-up on demand: A reads 0x010
    a_req_v = 1; a_req_we = 0; a_req_addr = 11'h010;
    n = 0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (pwr_state == 3'd2 && pgcb_isol_en) n++;
      if (pwr_state == 3'd3) got = 1;
    end
    check("iso_rel_cycles", n, ISO_SETTLE);
    check("first_on", {a_req_rdy, pgcb_isol_en, pwr_enable_b_in}, 32'h4);
    note_grant(0, 0, 11'h010, 16'd0, 1);
    @(posedge clk); #1;
    a_req_v = 0;

    // B read moves the pointer back to A, then contention
    do_req(1, 0, 11'h010, 16'd0, 1);
    a_req_v = 1; a_req_we = 1; a_req_addr = 11'h0AA; a_req_wdata = 16'h1234;
    b_req_v = 1; b_req_we = 0; b_req_addr = 11'h0AA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_order", {a_req_rdy, b_req_rdy}, (i % 2 == 0) ? 32'h2 : 32'h1);
      if (a_req_rdy) note_grant(0, 1, 11'h0AA, 16'h1234, 1);
      else if (b_req_rdy) note_grant(1, 0, 11'h0AA, 16'd0, 1);
      @(posedge clk); #1;
    end
    a_req_v = 0; b_req_v = 0;

    // Idle timeout
    n = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (pwr_state == 3'd3) n++; else got = 1;
    end
    check("idle_on_cycles", n, IDLE_LIMIT + 1);
    check("iso_on", {29'd0, pwr_state}, 32'd4);
    @(negedge clk);
    check("pwr_dn", {29'd0, pwr_state, pgcb_isol_en, pwr_enable_b_in}, 32'h17);

    // Request arriving in PWR_DN stalls until the block has cycled back to ON
    @(posedge clk); #1;
    b_req_v = 1; b_req_we = 0; b_req_addr = 11'h0AA;
    trace = 15'(pwr_state); got = 0; n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (pwr_state != trace[2:0]) trace = {trace[11:0], pwr_state};
      if (b_req_rdy && pwr_state != 3'd3) n++;
      if (b_req_rdy) got = 1;
    end
    check("stall_trace", trace, {3'd5, 3'd0, 3'd1, 3'd2, 3'd3});
    check("stall_no_rdy", n, 0);
    note_grant(1, 0, 11'h0AA, 16'd0, 1);
    @(posedge clk); #1;
    b_req_v = 0;
    repeat (4) @(negedge clk);

    // force_on from reset keeps the array powered
    @(posedge clk); #1;
    clk_rst = 1; force_on = 1;
    @(posedge clk); #1;
    clk_rst = 0;
    reached = 0; left = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pwr_state == 3'd3) reached = 1;
      else if (reached) left = 1;
    end
    check("force_on_hold", {reached, left, pwr_state}, {27'd0, 1'b1, 1'b0, 3'd3});

    // Reset the cycle after a read grant drops the response
    @(posedge clk); #1;
    do_req(0, 0, 11'h0AA, 16'd0, 0);
    clk_rst = 1; force_on = 0;
    @(posedge clk); #1;
    clk_rst = 0;
    @(negedge clk);
    check("mid_rst", {pwr_state, pwr_enable_b_in, pgcb_isol_en, rsp_v}, {3'd0, 3'b110});
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hqm_system_mem_pg_2048x16_ctl.md
Name: hqm_system_mem_pg_2048x16_ctl

Overview:
- Controller in front of the power-gated 2048x16 system SRAM wrapper.
- Shares the single-port array between two requesters (A, B) using round-robin arbitration, with valid/ready handshakes and a tagged read-return pipeline.
- Sequences power-gate enable, isolation and idle power-down: wakes on demand, powers down after an idle timeout.
- Array contents are not retained across power-down; owners treat the array as scratch.

Parameters:
- IDLE_LIMIT, 256: consecutive idle ON cycles before power-down starts (1..65535).
- ISO_SETTLE, 4: cycles between power ack and isolation release (1..15).
- RD_LAT, 1: SRAM read latency in cycles, re to rdata (1..3).

Ports:
- clk  in  1  clock
- clk_rst  in  1  reset; synchronous, active-high
- a_req_v  in  1  requester A valid
- a_req_we  in  1  A write(1)/read(0)
- a_req_addr  in  11  A address
- a_req_wdata  in  16  A write data
- a_req_rdy  out  1  A accepted this cycle
- b_req_v, b_req_we, b_req_addr, b_req_wdata, b_req_rdy: as A
- rsp_v  out  1  read data valid
- rsp_id  out  1  0=A, 1=B
- rsp_data  out  16  read data
- force_on  in  1  inhibit power-down; wake if off
- pwr_state  out  3  FSM state encoding, for status
- mem_re, mem_we  out  1  to SRAM
- mem_addr  out  11  to SRAM
- mem_wdata  out  16  to SRAM
- mem_rdata  in  16  from SRAM
- pgcb_isol_en  out  1  isolation enable to SRAM
- pwr_enable_b_in  out  1  power enable to SRAM, active-low
- pwr_enable_b_out  in  1  power ack from SRAM, active-low

Behaviour:
- Reset values:
  - state OFF(0); pwr_enable_b_in=1; pgcb_isol_en=1.
  - mem_re=mem_we=0; mem_addr=0; mem_wdata=0.
  - *_rdy=0; rsp_v=0; rsp_id=0; rsp_data=0.
  - RR pointer favours A; idle counter=0; RD_LAT pipeline cleared.
- FSM encodings: OFF=0, PWR_UP=1, ISO_REL=2, ON=3, ISO_ON=4, PWR_DN=5.
- OFF: exit to PWR_UP when any req_v or force_on.
- PWR_UP: drive pwr_enable_b_in=0; move to ISO_REL when pwr_enable_b_out==0.
- ISO_REL: count ISO_SETTLE cycles with isolation still asserted, then drop pgcb_isol_en and enter ON.
- ON: arbitration active.
  - Idle counter increments on each cycle with no grant, clears on a grant or force_on.
  - When the counter reaches IDLE_LIMIT and the read pipeline is empty, go to ISO_ON.
- ISO_ON: pgcb_isol_en=1 for 1 cycle, then PWR_DN.
- PWR_DN: pwr_enable_b_in=1; move to OFF when pwr_enable_b_out==1.
  - Requests arriving during ISO_ON/PWR_DN stall; the sequence completes to OFF, then re-wakes the next cycle.
- *_rdy is asserted only in ON. At most one grant per cycle.
- Arbitration: round-robin. The winner gets rdy combinationally in the same cycle as its valid; the pointer then moves to favour the other requester.
- Requesters hold v/we/addr/wdata stable until rdy.
- Grant drives mem_re or mem_we (never both), mem_addr and mem_wdata in the same cycle as rdy (combinational pass-through).
- Read return: rsp_v/rsp_id/rsp_data are registered and asserted exactly RD_LAT+1 cycles after the read grant.
  - rsp_data = mem_rdata sampled RD_LAT cycles after mem_re.
  - Back-to-back reads give back-to-back responses, in order.
- A write then a read to the same address in consecutive grants returns the new data; the SRAM handles this with no forwarding in this block.
- force_on held: never leaves ON.
- Reset mid-operation: everything returns to reset values in one cycle; in-flight responses are dropped.
- mem_re/mem_we are 0 outside ON.

Test Plan:
- Power-up from reset: assert a_req_v read addr 0x010 with ack returned 2 cycles after pwr_enable_b_in falls → ISO_REL for 4 cycles, isolation drops, a_req_rdy at first ON cycle, rsp_v with id 0 two cycles later.
- Contention with both requesters valid for 4 cycles: A writes 0x0AA=0x1234, B reads 0x0AA → grants alternate A,B,A,B; B's reads return 0x1234 after the first A write, rsp_id=1.
- Idle timeout with IDLE_LIMIT=8: no requests after the last response → ISO_ON at idle count 8, then PWR_DN, then OFF after ack; pwr_state sequence 3,4,5,0.
- Request during PWR_DN: b_req_v rises in PWR_DN → no rdy until OFF→PWR_UP→ISO_REL→ON; then grant.
- force_on asserted from reset, no requests for 1000 cycles → wakes and stays ON.
- Mid-read reset: clk_rst pulsed the cycle after a read grant → rsp_v never asserts; pwr_enable_b_in=1 and pgcb_isol_en=1 next cycle.
